// File: rtl/mem_port_arbiter_if.sv
// Bundle of the signals between the memory-port arbiter, its two requesters
// (instruction fetch and data access) and the shared memory.
//   master : requester / memory side (drives requests and mem_ready)
//   slave  : arbiter side (drives grant select, memory strobes, ack/err pulses)
//   req_if, req_mem   fetch / data request, held until ack or err
//   we_mem            data-side write enable, sampled at grant
//   mem_ready         memory has completed the current access
//   sel               external 2:1 mux select (0 = IF, 1 = MEM)
//   mem_req, mem_we   access valid / write enable to memory
//   ack_*, err_*      one-cycle completion / timeout pulses per requester
//   busy              transaction in flight
interface mem_port_arbiter_if;
   logic req_if;
   logic req_mem;
   logic we_mem;
   logic mem_ready;
   logic sel;
   logic mem_req;
   logic mem_we;
   logic ack_if;
   logic ack_mem;
   logic err_if;
   logic err_mem;
   logic busy;

   modport master (
      output req_if, req_mem, we_mem, mem_ready,
      input  sel, mem_req, mem_we, ack_if, ack_mem, err_if, err_mem, busy
   );

   modport slave (
      input  req_if, req_mem, we_mem, mem_ready,
      output sel, mem_req, mem_we, ack_if, ack_mem, err_if, err_mem, busy
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbiter for the single unified memory port shared by instruction fetch
// (requester 0) and data access (requester 1). Data has fixed priority; a
// burst counter forces fetch to win after MAX_DATA_BURST data grants taken
// while fetch was waiting. A timeout aborts a transaction the memory never
// completes.
//   clk  rising-edge clock
//   rst  synchronous, active-high reset
//   bus  mem_port_arbiter_if.slave (requests, memory handshake, ack/err)
//
// state | meaning
// IDLE  | no access in flight; arbitrate when any request is present
// BUSY  | access in flight; wait for mem_ready or timer terminal count
module mem_port_arbiter #(
   parameter int MAX_DATA_BURST = 4,
   parameter int TIMEOUT        = 16
) (
   input  logic              clk,
   input  logic              rst,
   mem_port_arbiter_if.slave bus
);
   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   localparam logic [3:0] BURST_MAX  = 4'(MAX_DATA_BURST);
   localparam logic [7:0] TIMER_LOAD = 8'(TIMEOUT - 1);

   state_t     state_q, state_d;
   logic       sel_q, sel_d;
   logic       we_q, we_d;
   logic [3:0] burst_cnt_q, burst_cnt_d;
   logic [7:0] timer_q, timer_d;

   logic win_if;
   logic in_busy;
   logic tmo;
   logic live;

   assign win_if  = bus.req_if & (~bus.req_mem | (burst_cnt_q == BURST_MAX));
   assign in_busy = (state_q == BUSY);
   // Timer counts down from TIMEOUT-1 loaded at grant, so terminal count 0
   // lands in the TIMEOUT-th BUSY cycle. mem_ready in that cycle wins.
   assign tmo     = in_busy & ~bus.mem_ready & (timer_q == 8'd0);
   // Outputs are forced low while rst is high so an access abandoned by
   // reset never produces a completion pulse.
   assign live    = in_busy & ~rst;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         sel_q       <= 1'b0;
         we_q        <= 1'b0;
         burst_cnt_q <= '0;
         timer_q     <= '0;
      end else begin
         state_q     <= state_d;
         sel_q       <= sel_d;
         we_q        <= we_d;
         burst_cnt_q <= burst_cnt_d;
         timer_q     <= timer_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      sel_d       = sel_q;
      we_d        = we_q;
      burst_cnt_d = burst_cnt_q;
      timer_d     = timer_q;
      case (state_q)
         IDLE: begin
            if (bus.req_if | bus.req_mem) begin
               state_d = BUSY;
               sel_d   = ~win_if;
               we_d    = ~win_if & bus.we_mem;
               timer_d = TIMER_LOAD;
               // Only data grants taken while fetch waits count toward
               // starvation; any other grant restarts the count.
               if (win_if || !bus.req_if) begin
                  burst_cnt_d = '0;
               end else if (burst_cnt_q != BURST_MAX) begin
                  burst_cnt_d = burst_cnt_q + 4'd1;
               end
            end
         end
         BUSY: begin
            if (bus.mem_ready || tmo) begin
               state_d = IDLE;
               timer_d = '0;
            end else begin
               timer_d = timer_q - 8'd1;
            end
         end
      endcase
   end

   always_comb begin
      bus.busy    = live;
      bus.mem_req = live;
      bus.sel     = sel_q & ~rst;
      bus.mem_we  = we_q & ~rst;
      bus.ack_if  = live & ~sel_q & bus.mem_ready;
      bus.ack_mem = live & sel_q & bus.mem_ready;
      bus.err_if  = live & ~sel_q & tmo;
      bus.err_mem = live & sel_q & tmo;
   end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a
// randomized run, checked against a transaction-level model of the
// arbitration and completion rules.
module tb_mem_port_arbiter;
   localparam int MAXB = 4;
   localparam int TMO  = 16;

   localparam int K_NONE    = 0;
   localparam int K_ACK_IF  = 1;
   localparam int K_ACK_MEM = 2;
   localparam int K_ERR_IF  = 3;
   localparam int K_ERR_MEM = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;

   mem_port_arbiter_if bus ();

   mem_port_arbiter #(
      .MAX_DATA_BURST(MAXB),
      .TIMEOUT       (TMO)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // model: data grants taken in a row while fetch was waiting
   int mb = 0;
   bit pend_if, pend_mem;

   // observations of the last transaction
   bit o_sel, o_we, o_unstable, o_idle_bad;
   int o_kind, o_cyc, o_npulse, o_len;

   function automatic bit model_grant(input bit r_if, input bit r_mem);
      bit m;
      m = r_mem && !(r_if && mb == MAXB);
      if (m && r_if) mb = (mb < MAXB) ? mb + 1 : MAXB;
      else mb = 0;
      return m;
   endfunction

   task automatic expect_of(input bit win_mem, input int lat, output int kind, output int cyc);
      if (lat >= 1 && lat <= TMO) begin
         kind = win_mem ? K_ACK_MEM : K_ACK_IF;
         cyc  = lat;
      end else begin
         kind = win_mem ? K_ERR_MEM : K_ERR_IF;
         cyc  = TMO;
      end
   endtask

   // Drives one request set from IDLE, raises mem_ready in BUSY cycle lat
   // (never if lat is 0 or beyond the timeout) and records what happened.
   task automatic do_txn(input bit r_if, input bit r_mem, input bit we, input int lat);
      int cyc;
      cyc = 0;
      bus.req_if    = r_if;
      bus.req_mem   = r_mem;
      bus.we_mem    = we;
      bus.mem_ready = 1'b0;
      @(posedge clk); #1;
      o_sel      = bus.sel;
      o_we       = bus.mem_we;
      o_kind     = K_NONE;
      o_cyc      = 0;
      o_npulse   = 0;
      o_unstable = 1'b0;
      while (bus.busy === 1'b1 && cyc < TMO + 4) begin
         cyc++;
         if (bus.sel !== o_sel || bus.mem_we !== o_we || bus.mem_req !== 1'b1) o_unstable = 1'b1;
         bus.mem_ready = (cyc == lat);
         #1;
         o_npulse += int'(bus.ack_if) + int'(bus.ack_mem) + int'(bus.err_if) + int'(bus.err_mem);
         if (o_kind == K_NONE) begin
            if (bus.ack_if === 1'b1) begin o_kind = K_ACK_IF; o_cyc = cyc; end
            else if (bus.ack_mem === 1'b1) begin o_kind = K_ACK_MEM; o_cyc = cyc; end
            else if (bus.err_if === 1'b1) begin o_kind = K_ERR_IF; o_cyc = cyc; end
            else if (bus.err_mem === 1'b1) begin o_kind = K_ERR_MEM; o_cyc = cyc; end
         end
         if (bus.ack_if === 1'b1 || bus.err_if === 1'b1) bus.req_if = 1'b0;
         if (bus.ack_mem === 1'b1 || bus.err_mem === 1'b1) bus.req_mem = 1'b0;
         @(posedge clk); #1;
      end
      o_len = cyc;
      o_idle_bad = ((bus.busy | bus.mem_req | bus.ack_if | bus.ack_mem | bus.err_if | bus.err_mem) !== 1'b0);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.req_if = 1'b1; bus.req_mem = 1'b1; bus.we_mem = 1'b1; bus.mem_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({bus.sel, bus.mem_req, bus.mem_we, bus.ack_if, bus.ack_mem, bus.err_if, bus.err_mem, bus.busy} !== 8'h00) begin
         errors++;
         $display("FAIL reset_outputs got %b want 00000000",
                  {bus.sel, bus.mem_req, bus.mem_we, bus.ack_if, bus.ack_mem, bus.err_if, bus.err_mem, bus.busy});
      end
      bus.req_if = 1'b0; bus.req_mem = 1'b0; bus.we_mem = 1'b0; bus.mem_ready = 1'b0;
      rst = 1'b0;
      mb = 0;
      @(posedge clk); #1;
      checks++;
      if ({bus.sel, bus.mem_req, bus.mem_we, bus.busy} !== 4'h0) begin
         errors++;
         $display("FAIL reset_idle got %b want 0000", {bus.sel, bus.mem_req, bus.mem_we, bus.busy});
      end
   endtask

   task automatic test_if_single();
      bit w; int k, c;
      w = model_grant(1'b1, 1'b0);
      expect_of(w, 3, k, c);
      do_txn(1'b1, 1'b0, 1'b0, 3);
      checks++;
      if (o_sel !== w || o_we !== 1'b0 || o_kind !== k || o_cyc !== c || o_len !== c ||
          o_npulse !== 1 || o_unstable || o_idle_bad) begin
         errors++;
         $display("FAIL if_single got sel=%0d we=%0d kind=%0d cyc=%0d len=%0d np=%0d unst=%0d idle=%0d want sel=%0d we=0 kind=%0d cyc=%0d",
                  o_sel, o_we, o_kind, o_cyc, o_len, o_npulse, o_unstable, o_idle_bad, w, k, c);
      end
   endtask

   task automatic test_back_to_back();
      bit w; int k, c;
      w = model_grant(1'b1, 1'b1);
      expect_of(w, 1, k, c);
      do_txn(1'b1, 1'b1, 1'b1, 1);
      checks++;
      if (o_sel !== 1'b1 || o_sel !== w || o_we !== (w & 1'b1) || o_kind !== k || o_cyc !== c ||
          o_len !== c || o_npulse !== 1 || o_unstable || o_idle_bad) begin
         errors++;
         $display("FAIL b2b_mem_first got sel=%0d we=%0d kind=%0d cyc=%0d len=%0d np=%0d unst=%0d idle=%0d want sel=1 we=1 kind=%0d cyc=%0d",
                  o_sel, o_we, o_kind, o_cyc, o_len, o_npulse, o_unstable, o_idle_bad, k, c);
      end
      w = model_grant(1'b1, 1'b0);
      expect_of(w, 1, k, c);
      do_txn(1'b1, 1'b0, 1'b1, 1);
      checks++;
      if (o_sel !== 1'b0 || o_sel !== w || o_we !== 1'b0 || o_kind !== k || o_cyc !== c ||
          o_len !== c || o_npulse !== 1 || o_unstable || o_idle_bad) begin
         errors++;
         $display("FAIL b2b_if_next got sel=%0d we=%0d kind=%0d cyc=%0d len=%0d np=%0d unst=%0d idle=%0d want sel=0 we=0 kind=%0d cyc=%0d",
                  o_sel, o_we, o_kind, o_cyc, o_len, o_npulse, o_unstable, o_idle_bad, k, c);
      end
   endtask

   task automatic test_starvation();
      bit exp_mem [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      bit w, we; int k, c;
      mb = 0;
      for (int i = 0; i < 10; i++) begin
         we = 1'($urandom_range(0, 1));
         w = model_grant(1'b1, 1'b1);
         expect_of(w, 1, k, c);
         do_txn(1'b1, 1'b1, we, 1);
         checks++;
         if (o_sel !== exp_mem[i] || o_sel !== w || o_we !== (w & we) || o_kind !== k ||
             o_cyc !== c || o_npulse !== 1 || o_unstable) begin
            errors++;
            $display("FAIL starve_order[%0d] got sel=%0d we=%0d kind=%0d cyc=%0d np=%0d unst=%0d want sel=%0d we=%0d kind=%0d cyc=%0d",
                     i, o_sel, o_we, o_kind, o_cyc, o_npulse, o_unstable, exp_mem[i], w & we, k, c);
         end
      end
   endtask

   task automatic test_timeout();
      bit r_if [3] = '{1'b0, 1'b1, 1'b0};
      bit r_mem [3] = '{1'b1, 1'b0, 1'b1};
      bit we [3] = '{1'b0, 1'b0, 1'b1};
      int lat [3] = '{0, 0, 2};
      bit w; int k, c;
      for (int i = 0; i < 3; i++) begin
         w = model_grant(r_if[i], r_mem[i]);
         expect_of(w, lat[i], k, c);
         do_txn(r_if[i], r_mem[i], we[i], lat[i]);
         checks++;
         if (o_sel !== w || o_we !== (w & we[i]) || o_kind !== k || o_cyc !== c ||
             o_len !== c || o_npulse !== 1 || o_unstable || o_idle_bad) begin
            errors++;
            $display("FAIL timeout[%0d] got sel=%0d we=%0d kind=%0d cyc=%0d len=%0d np=%0d unst=%0d idle=%0d want sel=%0d we=%0d kind=%0d cyc=%0d",
                     i, o_sel, o_we, o_kind, o_cyc, o_len, o_npulse, o_unstable, o_idle_bad, w, w & we[i], k, c);
         end
      end
   endtask

   task automatic test_timeout_boundary();
      bit w; int k, c;
      w = model_grant(1'b1, 1'b0);
      expect_of(w, TMO, k, c);
      do_txn(1'b1, 1'b0, 1'b0, TMO);
      checks++;
      if (o_kind !== K_ACK_IF || o_kind !== k || o_cyc !== TMO || o_npulse !== 1 || o_len !== c) begin
         errors++;
         $display("FAIL tmo_boundary_ack got kind=%0d cyc=%0d np=%0d len=%0d want kind=%0d cyc=%0d np=1",
                  o_kind, o_cyc, o_npulse, o_len, K_ACK_IF, TMO);
      end
      w = model_grant(1'b0, 1'b1);
      expect_of(w, TMO - 1, k, c);
      do_txn(1'b0, 1'b1, 1'b0, TMO - 1);
      checks++;
      if (o_kind !== k || o_cyc !== c || o_npulse !== 1 || o_len !== c) begin
         errors++;
         $display("FAIL tmo_minus1_ack got kind=%0d cyc=%0d np=%0d len=%0d want kind=%0d cyc=%0d np=1",
                  o_kind, o_cyc, o_npulse, o_len, k, c);
      end
   endtask

   task automatic test_reset_busy();
      bit w; int k, c;
      bus.req_if = 1'b0; bus.req_mem = 1'b1; bus.we_mem = 1'b1; bus.mem_ready = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (bus.busy !== 1'b1 || bus.sel !== 1'b1 || bus.mem_we !== 1'b1) begin
         errors++;
         $display("FAIL rb_grant got busy=%0d sel=%0d we=%0d want 1 1 1", bus.busy, bus.sel, bus.mem_we);
      end
      @(posedge clk); #1;
      rst = 1'b1;
      bus.mem_ready = 1'b1;
      #1;
      checks++;
      if ({bus.ack_if, bus.ack_mem, bus.err_if, bus.err_mem} !== 4'h0) begin
         errors++;
         $display("FAIL rb_no_ack got %b want 0000", {bus.ack_if, bus.ack_mem, bus.err_if, bus.err_mem});
      end
      @(posedge clk); #1;
      rst = 1'b0;
      bus.req_mem = 1'b0; bus.mem_ready = 1'b0; bus.we_mem = 1'b0;
      mb = 0;
      #1;
      checks++;
      if ({bus.sel, bus.mem_req, bus.mem_we, bus.ack_if, bus.ack_mem, bus.err_if, bus.err_mem, bus.busy} !== 8'h00) begin
         errors++;
         $display("FAIL rb_after got %b want 00000000",
                  {bus.sel, bus.mem_req, bus.mem_we, bus.ack_if, bus.ack_mem, bus.err_if, bus.err_mem, bus.busy});
      end
      w = model_grant(1'b1, 1'b0);
      expect_of(w, 1, k, c);
      do_txn(1'b1, 1'b0, 1'b0, 1);
      checks++;
      if (o_sel !== w || o_kind !== k || o_cyc !== c || o_npulse !== 1 || o_idle_bad) begin
         errors++;
         $display("FAIL rb_recover got sel=%0d kind=%0d cyc=%0d np=%0d idle=%0d want sel=%0d kind=%0d cyc=%0d",
                  o_sel, o_kind, o_cyc, o_npulse, o_idle_bad, w, k, c);
      end
   endtask

   task automatic test_random();
      bit w, we; int k, c, lat;
      pend_if = 1'b0; pend_mem = 1'b0;
      for (int i = 0; i < 60; i++) begin
         if (!pend_if) pend_if = 1'($urandom_range(0, 1));
         if (!pend_mem) pend_mem = 1'($urandom_range(0, 1));
         if (!pend_if && !pend_mem) begin
            bus.req_if = 1'b0; bus.req_mem = 1'b0;
            bus.mem_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            checks++;
            if (bus.busy !== 1'b0 || bus.ack_if !== 1'b0 || bus.ack_mem !== 1'b0) begin
               errors++;
               $display("FAIL rnd_idle[%0d] got busy=%0d ack_if=%0d ack_mem=%0d want 0 0 0",
                        i, bus.busy, bus.ack_if, bus.ack_mem);
            end
         end else begin
            we  = 1'($urandom_range(0, 1));
            lat = ($urandom_range(0, 3) != 0) ? int'($urandom_range(1, 4)) : int'($urandom_range(0, TMO + 2));
            w = model_grant(pend_if, pend_mem);
            expect_of(w, lat, k, c);
            do_txn(pend_if, pend_mem, we, lat);
            checks++;
            if (o_sel !== w || o_we !== (w & we) || o_kind !== k || o_cyc !== c ||
                o_len !== c || o_npulse !== 1 || o_unstable || o_idle_bad) begin
               errors++;
               $display("FAIL rnd_txn[%0d] got sel=%0d we=%0d kind=%0d cyc=%0d len=%0d np=%0d unst=%0d idle=%0d want sel=%0d we=%0d kind=%0d cyc=%0d",
                        i, o_sel, o_we, o_kind, o_cyc, o_len, o_npulse, o_unstable, o_idle_bad, w, w & we, k, c);
            end
            if (w) pend_mem = 1'b0;
            else pend_if = 1'b0;
         end
      end
   endtask

   initial begin
      bus.req_if = 1'b0; bus.req_mem = 1'b0; bus.we_mem = 1'b0; bus.mem_ready = 1'b0;
      test_reset();
      test_if_single();
      test_back_to_back();
      test_starvation();
      test_timeout();
      test_timeout_boundary();
      test_reset_busy();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog simulation time limit reached checks=%0d errors=%0d", checks, errors);
      $fatal(1);
   end
endmodule
